// File: rtl/snake_pkg.sv
// Shared SnakeWars types: game modes, button ids and on-screen button geometry.
// Pure declarations plus a combinational hit-box helper; no state.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    ERROR  = 2'd1,
    GAME   = 2'd2,
    ENDSCR = 2'd3
  } game_mode;

  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_PLAY  = 3'd1,
    BTN_SPEED = 3'd2,
    BTN_COLOR = 3'd3,
    BTN_BACK  = 3'd4
  } btn_id_t;

  // All buttons share one column and one height; only the top edge differs.
  localparam logic [11:0] BUTTONS_X = 12'd412;
  localparam logic [11:0] BUTTONS_W = 12'd200;
  localparam logic [11:0] BUTTONS_H = 12'd60;
  localparam logic [11:0] BUTTON1_Y = 12'd200;
  localparam logic [11:0] BUTTON2_Y = 12'd300;
  localparam logic [11:0] BUTTON3_Y = 12'd400;
  localparam logic [11:0] BUTTONE_Y = 12'd500;

  localparam logic [1:0] SPEED_MIN = 2'd1;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] top);
    return (x >= BUTTONS_X) && (x < BUTTONS_X + BUTTONS_W) &&
           (y >= top) && (y < top + BUTTONS_H);
  endfunction

endpackage

// File: rtl/snake_click_tracker.sv
// Mouse-button edge detector and pending-press latch; click_valid is combinational
// in the release cycle, pending press updates one cycle after the press edge.
module snake_click_tracker
  import snake_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    mouse_left_i,
  input  btn_id_t hit_i,
  input  logic    clear_i,
  output logic    press_rise_o,
  output logic    click_valid_o,
  output btn_id_t click_id_o
);

  logic    mouse_q;
  btn_id_t pend_q, pend_d;
  logic    release_fall;

  assign press_rise_o  = mouse_left_i & ~mouse_q;
  assign release_fall  = ~mouse_left_i & mouse_q;
  assign click_valid_o = release_fall && (pend_q == hit_i) && (hit_i != BTN_NONE);
  assign click_id_o    = pend_q;

  // A mode change invalidates any press made against the old screen layout.
  always_comb begin
    pend_d = pend_q;
    if (clear_i) begin
      pend_d = BTN_NONE;
    end else if (press_rise_o) begin
      pend_d = hit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mouse_q <= 1'b0;
      pend_q  <= BTN_NONE;
    end else begin
      mouse_q <= mouse_left_i;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: rtl/snake_mode_ctrl.sv
// SnakeWars mode sequencer: button hit-test, click-to-action, timeouts and link watchdog.
// hover lags the cursor by 1 cycle; click actions land 1 cycle after the release cycle.
module snake_mode_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned ERR_TIMEOUT = 195_000_000,
  parameter int unsigned END_LOCK    = 65_000_000,
  parameter int unsigned LINK_LOSS   = 1024,
  parameter int unsigned CNT_W       = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        link_ok,
  input  logic        game_over,
  output game_mode    mode,
  output btn_id_t     hover,
  output logic [1:0]  speed,
  output logic [1:0]  color,
  output logic        game_start
);

  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] END_LIM   = CNT_W'(END_LOCK);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LINK_LOSS - 1);

  game_mode         mode_q, mode_d;
  btn_id_t          hover_q, hit;
  logic [1:0]       speed_q, speed_d;
  logic [1:0]       color_q, color_d;
  logic             game_start_q, game_start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             mode_chg;
  logic             press_rise, click_valid;
  btn_id_t          click_id;

  always_comb begin
    hit = BTN_NONE;
    unique case (mode_q)
      MENU: begin
        if (in_box(xpos, ypos, BUTTON1_Y))      hit = BTN_PLAY;
        else if (in_box(xpos, ypos, BUTTON2_Y)) hit = BTN_SPEED;
        else if (in_box(xpos, ypos, BUTTON3_Y)) hit = BTN_COLOR;
      end
      ERROR: begin
        if (in_box(xpos, ypos, BUTTONE_Y))      hit = BTN_BACK;
      end
      default: hit = BTN_NONE;
    endcase
  end

  snake_click_tracker u_click (
    .clk           (clk),
    .rst_n         (rst_n),
    .mouse_left_i  (mouse_left),
    .hit_i         (hit),
    .clear_i       (mode_chg),
    .press_rise_o  (press_rise),
    .click_valid_o (click_valid),
    .click_id_o    (click_id)
  );

  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    color_d = color_q;
    loss_d  = '0;
    unique case (mode_q)
      MENU: begin
        if (click_valid) begin
          unique case (click_id)
            BTN_PLAY:  mode_d  = link_ok ? GAME : ERROR;
            BTN_SPEED: speed_d = (speed_q >= SPEED_MAX) ? SPEED_MIN : speed_q + 2'd1;
            BTN_COLOR: color_d = color_q + 2'd1;
            default:   mode_d  = mode_q;
          endcase
        end
      end
      ERROR: begin
        if ((click_valid && click_id == BTN_BACK) || cnt_q >= ERR_LAST) mode_d = MENU;
      end
      GAME: begin
        // game_over takes precedence over a simultaneous link loss.
        if (game_over)                                 mode_d = ENDSCR;
        else if (!link_ok && loss_q >= LOSS_LAST)      mode_d = ERROR;
        if (!link_ok) loss_d = (loss_q == '1) ? loss_q : loss_q + 1'b1;
      end
      ENDSCR: begin
        if (press_rise && cnt_q >= END_LIM) mode_d = MENU;
      end
      default: mode_d = MENU;
    endcase

    mode_chg     = (mode_d != mode_q);
    cnt_d        = mode_chg ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
    if (mode_chg) loss_d = '0;
    game_start_d = (mode_q == MENU) && (mode_d == GAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MENU;
      hover_q      <= BTN_NONE;
      speed_q      <= SPEED_MIN;
      color_q      <= 2'd0;
      game_start_q <= 1'b0;
      cnt_q        <= '0;
      loss_q       <= '0;
    end else begin
      mode_q       <= mode_d;
      hover_q      <= hit;
      speed_q      <= speed_d;
      color_q      <= color_d;
      game_start_q <= game_start_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
    end
  end

  assign mode       = mode_q;
  assign hover      = hover_q;
  assign speed      = speed_q;
  assign color      = color_q;
  assign game_start = game_start_q;

endmodule

// File: tb/tb_snake_mode_ctrl.sv
// Self-checking bench for snake_mode_ctrl with shortened timeouts.
module tb_snake_mode_ctrl;
  import snake_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos, ypos;
  logic        mouse_left, link_ok, game_over;
  game_mode    mode;
  btn_id_t     hover;
  logic [1:0]  speed, color;
  logic        game_start;

  int total = 0;
  int bad   = 0;
  int gs_cnt = 0;

  typedef struct {
    game_mode   m;
    logic [1:0] s;
    logic [1:0] c;
  } exp_t;
  exp_t sb[$];

  localparam logic [11:0] X0 = BUTTONS_X + 12'd10;

  snake_mode_ctrl #(
    .ERR_TIMEOUT (100),
    .END_LOCK    (50),
    .LINK_LOSS   (8),
    .CNT_W       (28)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xpos       (xpos),
    .ypos       (ypos),
    .mouse_left (mouse_left),
    .link_ok    (link_ok),
    .game_over  (game_over),
    .mode       (mode),
    .hover      (hover),
    .speed      (speed),
    .color      (color),
    .game_start (game_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (game_start) gs_cnt++;
  endtask

  task automatic expect_state(input game_mode m, input logic [1:0] s, input logic [1:0] c);
    exp_t e;
    e.m = m; e.s = s; e.c = c;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_depth"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_mode"},  int'(mode),  int'(e.m));
      check_eq({tag, "_speed"}, int'(speed), int'(e.s));
      check_eq({tag, "_color"}, int'(color), int'(e.c));
    end
  endtask

  task automatic click_at(input logic [11:0] x, input logic [11:0] y);
    xpos = x; ypos = y;
    tick();
    mouse_left = 1'b1;
    tick();
    tick();
    mouse_left = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] spd, col;
    int n;
    rst_n = 1'b0; xpos = '0; ypos = '0;
    mouse_left = 1'b0; link_ok = 1'b1; game_over = 1'b0;
    repeat (3) tick();
    check_eq("rst_mode",  int'(mode),  int'(MENU));
    check_eq("rst_hover", int'(hover), int'(BTN_NONE));
    check_eq("rst_speed", int'(speed), 1);
    check_eq("rst_color", int'(color), 0);
    check_eq("rst_gs",    int'(game_start), 0);
    rst_n = 1'b1;
    tick();

    // hit-box boundaries, hover one cycle behind the cursor
    xpos = BUTTONS_X; ypos = BUTTON1_Y; tick();
    check_eq("hov_lo_corner", int'(hover), int'(BTN_PLAY));
    xpos = BUTTONS_X + BUTTONS_W - 12'd1; ypos = BUTTON1_Y + BUTTONS_H - 12'd1; tick();
    check_eq("hov_hi_corner", int'(hover), int'(BTN_PLAY));
    xpos = BUTTONS_X + BUTTONS_W; tick();
    check_eq("hov_x_excl", int'(hover), int'(BTN_NONE));
    xpos = BUTTONS_X; ypos = BUTTON2_Y; tick();
    check_eq("hov_speed", int'(hover), int'(BTN_SPEED));
    ypos = BUTTON3_Y + BUTTONS_H; tick();
    check_eq("hov_y_excl", int'(hover), int'(BTN_NONE));
    ypos = BUTTONE_Y + 12'd10; tick();
    check_eq("hov_back_in_menu", int'(hover), int'(BTN_NONE));

    game_over = 1'b1; tick(); game_over = 1'b0;
    check_eq("gameover_in_menu", int'(mode), int'(MENU));

    // 1: play with link up
    expect_state(GAME, 2'd1, 2'd0);
    click_at(X0, BUTTON1_Y + 12'd10);
    check_sb("t1_play");
    check_eq("t1_gs_hi", int'(game_start), 1);
    tick();
    check_eq("t1_gs_lo", int'(game_start), 0);
    check_eq("t1_hover_game", int'(hover), int'(BTN_NONE));

    // 5a: link loss needs 8 consecutive low cycles
    link_ok = 1'b0;
    repeat (7) tick();
    check_eq("t5_7low", int'(mode), int'(GAME));
    link_ok = 1'b1; tick();
    link_ok = 1'b0;
    repeat (7) tick();
    check_eq("t5_2nd_7low", int'(mode), int'(GAME));
    tick();
    check_eq("t5_8low", int'(mode), int'(ERROR));

    // 2: error timeout is exactly 100 cycles
    n = 0;
    while (mode == ERROR && n < 200) begin
      tick();
      n++;
    end
    check_eq("t2_err_cycles", n, 100);
    check_eq("t2_back_menu", int'(mode), int'(MENU));

    expect_state(ERROR, 2'd1, 2'd0);
    click_at(X0, BUTTON1_Y + 12'd10);
    check_sb("t2_play_nolink");
    tick();
    check_eq("t2_hover_err_play", int'(hover), int'(BTN_NONE));
    expect_state(MENU, 2'd1, 2'd0);
    click_at(X0, BUTTONE_Y + 12'd10);
    check_sb("t2_back_click");

    // 3: speed and colour cycling
    spd = 2'd1; col = 2'd0;
    for (int i = 0; i < 3; i++) begin
      spd = (spd == 2'd3) ? 2'd1 : spd + 2'd1;
      expect_state(MENU, spd, col);
      click_at(X0, BUTTON2_Y + 12'd10);
      check_sb("t3_speed");
    end
    for (int i = 0; i < 5; i++) begin
      col = col + 2'd1;
      expect_state(MENU, spd, col);
      click_at(X0, BUTTON3_Y + 12'd10);
      check_sb("t3_color");
    end

    // 4: press/release mismatches do nothing
    expect_state(MENU, spd, col);
    xpos = X0; ypos = BUTTON2_Y + 12'd10; tick();
    mouse_left = 1'b1; tick();
    ypos = BUTTON3_Y + 12'd10; tick();
    mouse_left = 1'b0; tick(); tick();
    check_sb("t4_drag");
    expect_state(MENU, spd, col);
    xpos = 12'd0; ypos = 12'd0; tick();
    mouse_left = 1'b1; tick();
    xpos = X0; ypos = BUTTON2_Y + 12'd10; tick();
    mouse_left = 1'b0; tick(); tick();
    check_sb("t4_none_press");

    spd = 2'd2;
    expect_state(MENU, spd, col);
    click_at(X0, BUTTON2_Y + 12'd10);
    check_sb("t4_speed2");

    // 5b: game_over beats a simultaneous link loss
    link_ok = 1'b1;
    expect_state(GAME, spd, col);
    click_at(X0, BUTTON1_Y + 12'd10);
    check_sb("t5_play");
    link_ok = 1'b0;
    repeat (7) tick();
    game_over = 1'b1; tick(); game_over = 1'b0;
    check_eq("t5_gameover_wins", int'(mode), int'(ENDSCR));

    // 6: end-screen lockout
    repeat (9) tick();
    mouse_left = 1'b1; tick();
    check_eq("t6_locked_press", int'(mode), int'(ENDSCR));
    mouse_left = 1'b0; tick();
    check_eq("t6_locked_rel", int'(mode), int'(ENDSCR));
    repeat (48) tick();
    expect_state(MENU, spd, col);
    mouse_left = 1'b1; tick();
    check_sb("t6_unlock");
    mouse_left = 1'b0; tick();

    link_ok = 1'b1;
    expect_state(GAME, spd, col);
    click_at(X0, BUTTON1_Y + 12'd10);
    check_sb("t6_play");
    tick();

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_mode",  int'(mode),  int'(MENU));
    check_eq("arst_speed", int'(speed), 1);
    check_eq("arst_color", int'(color), 0);
    check_eq("arst_hover", int'(hover), int'(BTN_NONE));
    repeat (2) tick();
    check_eq("arst_gs", int'(game_start), 0);
    check_eq("gs_pulses", gs_cnt, 3);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
